// File: rtl/mux_pkg.sv
// Shared constants for the round-robin stream multiplexer.
// Mode encodings used by the top-level grant selection.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from ptr+1 upward, wrapping.
// Pointer moves to the winner only when advance is pulsed.
module rr_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         req,
  input  logic                      advance,
  output logic [NUM_CH-1:0]         grant,
  output logic [$clog2(NUM_CH)-1:0] grant_idx,
  output logic                      grant_vld
);

  localparam int IW = $clog2(NUM_CH);

  logic [IW-1:0] ptr;
  int            idx;

  // Descending scan so the nearest requester after ptr wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = (int'(ptr) + i) % NUM_CH;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
        grant_vld  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= IW'(NUM_CH - 1);
    end else if (advance && grant_vld) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/mux_rr_stream.sv
// N:1 stream mux with fixed or round-robin selection
// and a single full-throughput output register.
module mux_rr_stream
  import mux_pkg::*;
#(
  parameter  int DATA_WIDTH = 4,
  parameter  int NUM_CH     = 4,
  localparam int SEL_W      = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mode,
  input  logic [SEL_W-1:0]             sel,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]             out_ch,
  output logic                         out_valid,
  input  logic                         out_ready
);

  logic                  load_en;
  logic                  take;
  logic                  fix_vld;
  logic [NUM_CH-1:0]     rr_grant;
  logic [SEL_W-1:0]      rr_idx;
  logic                  rr_vld;
  logic [SEL_W-1:0]      g_idx;
  logic                  g_vld;
  logic [DATA_WIDTH-1:0] g_data;

  assign load_en = !out_valid || out_ready;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (in_valid),
    .advance   (take && (mode == MODE_RR)),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .grant_vld (rr_vld)
  );

  // Out-of-range sel never matches, so it yields no grant.
  always_comb begin
    fix_vld = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(sel) == k) fix_vld = in_valid[k];
    end
  end

  always_comb begin
    if (mode == MODE_RR) begin
      g_idx = rr_idx;
      g_vld = rr_vld;
    end else begin
      g_idx = sel;
      g_vld = fix_vld;
    end
  end

  assign take = load_en && g_vld;

  always_comb begin
    g_data   = '0;
    in_ready = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(g_idx) == k) begin
        g_data      = in_data[k*DATA_WIDTH +: DATA_WIDTH];
        in_ready[k] = take;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
    end else if (take) begin
      out_data  <= g_data;
      out_ch    <= g_idx;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_stream.sv
// Directed bench for mux_rr_stream: a 4-channel and
// a 3-channel instance driven by hand-computed vectors.
module tb_mux_rr_stream;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_mode;
  logic [1:0]  a_sel;
  logic [15:0] a_data;
  logic [3:0]  a_valid;
  logic [3:0]  a_ready;
  logic [3:0]  a_odata;
  logic [1:0]  a_och;
  logic        a_ovalid;
  logic        a_oready;

  logic        b_mode;
  logic [1:0]  b_sel;
  logic [11:0] b_data;
  logic [2:0]  b_valid;
  logic [2:0]  b_ready;
  logic [3:0]  b_odata;
  logic [1:0]  b_och;
  logic        b_ovalid;
  logic        b_oready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux_rr_stream #(.DATA_WIDTH(4), .NUM_CH(4)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .mode      (a_mode),
    .sel       (a_sel),
    .in_data   (a_data),
    .in_valid  (a_valid),
    .in_ready  (a_ready),
    .out_data  (a_odata),
    .out_ch    (a_och),
    .out_valid (a_ovalid),
    .out_ready (a_oready)
  );

  mux_rr_stream #(.DATA_WIDTH(4), .NUM_CH(3)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .mode      (b_mode),
    .sel       (b_sel),
    .in_data   (b_data),
    .in_valid  (b_valid),
    .in_ready  (b_ready),
    .out_data  (b_odata),
    .out_ch    (b_och),
    .out_valid (b_ovalid),
    .out_ready (b_oready)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_ch [5];
  logic [3:0] exp_d  [5];

  initial begin
    rst      = 1'b1;
    a_mode   = 1'b0;
    a_sel    = 2'd0;
    a_data   = 16'hDCBA;
    a_valid  = 4'b0000;
    a_oready = 1'b1;
    b_mode   = 1'b0;
    b_sel    = 2'd0;
    b_data   = 12'hCBA;
    b_valid  = 3'b000;
    b_oready = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(a_ovalid), 0);
    chk("rst_data", 32'(a_odata), 0);
    chk("rst_ch", 32'(a_och), 0);
    rst = 1'b0;
    tick();

    // fixed select sweep
    a_valid = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      a_sel = 2'(s);
      #1;
      chk("fix_rdy", 32'(a_ready), 32'(1 << s));
      tick();
      chk("fix_data", 32'(a_odata), 32'(10 + s));
      chk("fix_ch", 32'(a_och), 32'(s));
      chk("fix_vld", 32'(a_ovalid), 1);
    end

    // round robin, all valid; ptr untouched by fixed mode
    a_mode = 1'b1;
    exp_ch = '{0, 1, 2, 3, 0};
    exp_d  = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rr_rdy", 32'(a_ready), 32'(1 << exp_ch[i]));
      tick();
      chk("rr_ch", 32'(a_och), 32'(exp_ch[i]));
      chk("rr_data", 32'(a_odata), 32'(exp_d[i]));
    end

    // round robin, ch1 and ch3 only
    a_valid = 4'b1010;
    exp_ch  = '{1, 3, 1, 3, 1};
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr13_rdy", 32'(a_ready), 32'(1 << exp_ch[i]));
      tick();
      chk("rr13_ch", 32'(a_och), 32'(exp_ch[i]));
    end

    // backpressure: ptr=3, next grant ch0
    a_valid = 4'b1111;
    tick();
    chk("bp_load_ch", 32'(a_och), 0);
    a_oready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_rdy", 32'(a_ready), 0);
      tick();
      chk("bp_ch", 32'(a_och), 0);
      chk("bp_data", 32'(a_odata), 32'hA);
      chk("bp_vld", 32'(a_ovalid), 1);
    end
    a_oready = 1'b1;
    #1;
    chk("bp_rel_rdy", 32'(a_ready), 32'b0010);
    tick();
    chk("bp_rel_ch", 32'(a_och), 1);
    chk("bp_rel_data", 32'(a_odata), 32'hB);
    a_valid = 4'b0000;
    tick();
    chk("drain_vld", 32'(a_ovalid), 0);
    chk("drain_hold", 32'(a_odata), 32'hB);
    chk("drain_ch", 32'(a_och), 1);

    // async reset during a stall
    a_valid = 4'b1111;
    tick();
    chk("pre_rst_ch", 32'(a_och), 2);
    a_oready = 1'b0;
    tick();
    chk("stall_vld", 32'(a_ovalid), 1);
    rst = 1'b1;
    #1;
    chk("arst_vld", 32'(a_ovalid), 0);
    chk("arst_data", 32'(a_odata), 0);
    chk("arst_ch", 32'(a_och), 0);
    tick();
    rst      = 1'b0;
    a_oready = 1'b1;
    tick();
    chk("post_rst_ch", 32'(a_och), 0);
    chk("post_rst_data", 32'(a_odata), 32'hA);

    // three-channel instance
    b_valid = 3'b111;
    b_sel   = 2'd3;
    #1;
    chk("b_sel3_rdy", 32'(b_ready), 0);
    tick();
    chk("b_sel3_vld", 32'(b_ovalid), 0);
    b_mode  = 1'b1;
    b_valid = 3'b100;
    #1;
    chk("b_rr2_rdy", 32'(b_ready), 32'b100);
    tick();
    chk("b_rr2_ch", 32'(b_och), 2);
    chk("b_rr2_data", 32'(b_odata), 32'hC);
    b_valid = 3'b111;
    tick();
    chk("b_wrap_ch", 32'(b_och), 0);
    chk("b_wrap_data", 32'(b_odata), 32'hA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
